// File: rtl/mul_div_unit_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: operation request,
// MTHI/MTLO writes, and the status/result outputs.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per RUN cycle, sign fix-up in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_fix;

  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_b_zero;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- operand magnitudes
  always_comb begin
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.a[WIDTH-1];
    w_b_neg  = w_signed & bus.b[WIDTH-1];
    w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // ------------------------------------------------------ iteration step
  // Multiply shifts {acc,q} right after adding the multiplicand into acc;
  // divide shifts {acc,q} left and subtracts the divisor when it fits.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b_mag} : '0);
    w_div_shift = {r_acc, r_q[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
    w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    if (r_is_div) begin
      w_acc_nxt = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_nxt = w_mul_sum[WIDTH:1];
      w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end
  end

  // ------------------------------------------------------- FIX results
  always_comb begin
    w_prod   = {r_acc, r_q};
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo_s  = r_neg_q ? (~r_q + 1'b1) : r_q;
    w_rem_s  = r_neg_r ? (~r_acc + 1'b1) : r_acc;
    if (!r_is_div) begin
      w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_s[WIDTH-1:0];
    end else if (r_b_zero) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem_s;
      w_fix_lo = w_quo_s;
    end
  end

  // ------------------------------------------------ working registers
  // NOTE: these datapath flops are always loaded at accept before they are
  // read, so they carry no reset; only architectural/control state is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc    <= '0;
      r_q      <= w_a_mag;
      r_b_mag  <= w_b_mag;
      r_a_raw  <= bus.a;
      r_is_div <= bus.op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b_zero <= (bus.b == '0);
    end else if (w_step) begin
      r_acc    <= w_acc_nxt;
      r_q      <= w_q_nxt;
    end
  end

  // ------------------------------------- counter, HI/LO, status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= w_fix;
      if (w_accept)    r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;

      // MTHI/MTLO only land while idle; a write alongside start lands now
      // and is later overwritten by the result in FIX.
      if (w_fix) begin
        r_hi       <= w_fix_hi;
        r_lo       <= w_fix_lo;
        r_div_zero <= r_is_div & r_b_zero;
      end else if (r_state == S_IDLE) begin
        if (bus.wr_hi) r_hi <= bus.wr_data;
        if (bus.wr_lo) r_lo <= bus.wr_data;
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO/div_zero
// from a 64-bit arithmetic model, plus latency, busy, MTHI/MTLO and reset checks.
module tb_mul_div_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        r;
    longint      sa, sb, q, rm;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    r    = '0;
    case (op)
      2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b10: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1; r.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0; r.lo = 32'h8000_0000;
        end else begin
          q = sa / sb; rm = sa % sb;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end
      end
      default: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1; r.dz = 1'b1;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to done, compare against the scoreboard.
  // poke_busy: try MTLO and a conflicting start mid-operation.
  // wr_with_start: MTLO in the accept cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke_busy, input bit wr_with_start);
    exp_t         e;
    int           lat;
    int           busy_cnt;
    logic [W-1:0] lo_before;
    lo_before = '0;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (wr_with_start) begin
      bus.wr_lo   = 1'b1;
      bus.wr_data = 32'h1357_9BDF;
    end
    sb_q.push_back(model(op, a, b));
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (wr_with_start) begin
      check({tag, " lo_wr_at_start"}, bus.lo, 32'h1357_9BDF);
      bus.wr_lo = 1'b0;
    end
    busy_cnt = bus.busy ? 1 : 0;
    lat      = 0;
    while (!bus.done && lat < 3 * W) begin
      if (poke_busy && lat == 5) begin
        lo_before   = bus.lo;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h5555_AAAA;
        bus.start   = 1'b1;
        bus.op      = ~op;
        bus.a       = 32'd9;
        bus.b       = 32'd3;
      end
      tick();
      lat++;
      if (poke_busy && lat == 6) begin
        check({tag, " lo_busy_wr"}, bus.lo, lo_before);
        bus.wr_lo = 1'b0;
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
    end
    check({tag, " done"}, bus.done, 1'b1);
    check({tag, " latency"}, lat, W + 1);
    check({tag, " busy_cycles"}, busy_cnt, W + 1);
    if (sb_q.size() == 0) begin
      check({tag, " sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " hi"}, bus.hi, e.hi);
      check({tag, " lo"}, bus.lo, e.lo);
      check({tag, " div_zero"}, bus.div_zero, e.dz);
    end
    tick();
    check({tag, " done_pulse"}, bus.done, 1'b0);
    check({tag, " idle_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_seen;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset dz",   bus.div_zero, 1'b0);
    check("reset hi",   bus.hi, 32'h0);
    check("reset lo",   bus.lo, 32'h0);
    rst_n = 1'b1;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_7_2",  2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_by0",  2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op("multu_2x3", 2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
    run_op("div_by0_s", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    run_op("div_7_m2",  2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // MTHI while idle
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'hAAAA_0000;
    tick();
    bus.wr_hi   = 1'b0;
    check("mthi hi", bus.hi, 32'hAAAA_0000);

    run_op("multu_wr_start", 2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
    run_op("mult_poke",      2'b00, 32'hFFFF_1234, 32'h0000_7777, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0, 1'b0);
    end

    // Reset mid-operation: abandon, no result write, no done.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h0000_FFFF; bus.b = 32'h0000_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("rst_mid busy_before", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", bus.busy, 1'b0);
    check("rst_mid hi",   bus.hi, 32'h0);
    check("rst_mid lo",   bus.lo, 32'h0);
    check("rst_mid done", bus.done, 1'b0);
    check("rst_mid dz",   bus.div_zero, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < W + 8; c++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("rst_mid no_done", done_seen, 0);
    check("rst_mid hi_after", bus.hi, 32'h0);

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle HI/LO multiply/divide unit for the MIPS datapath, replacing the single-cycle, unsigned-only DIV path and HI/LO registers in the combinational ALU. It executes MULT, MULTU, DIV and DIVU iteratively over WIDTH+1 cycles and owns the architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO combinationally for MFHI/MFLO. The ALU keeps all single-cycle ops; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation; accepted only when `busy`=0.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (rs); sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor (rt); sampled with `start`.
- `wr_hi`  in  1  MTHI: write `wr_data` to HI.
- `wr_lo`  in  1  MTLO: write `wr_data` to LO.
- `wr_data`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO hold the new result.
- `div_zero`  out  1  last completed operation was a divide with `b`=0; held until the next completion.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: on `start`, latch operands, go to RUN.
  - RUN: cycle counter runs 0..WIDTH-1; go to FIX after the iteration at count WIDTH-1.
  - FIX: write HI/LO, pulse `done`, return to IDLE.
- Signed ops (MULT, DIV) convert operands to magnitudes at accept. The result sign is recorded at accept and applied in FIX.
- Multiply: radix-2 shift-add over the unsigned magnitudes into a 2·WIDTH product.
  - FIX writes HI = product[2W-1:W] and LO = product[W-1:0].
  - Signed result is the 2·WIDTH two's-complement negation of the product when the operand signs differ.
- Divide: restoring division, one quotient bit per RUN cycle.
  - FIX writes LO = quotient and HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / −1 (signed): LO = MIN, HI = 0; no trap.
- Divide by zero (either divide op): HI = `a`, LO = all ones, `div_zero`=1. This path takes the same latency as a normal divide.
- `div_zero` updates only in FIX: 1 for a divide by zero, 0 otherwise.
- MTHI/MTLO:
  - `wr_hi`/`wr_lo` are applied at the clock edge only while `busy`=0; ignored while busy.
  - A write and `start` in the same idle cycle are both accepted. The write lands now; the operation's result overwrites HI/LO at FIX.
- `start` while `busy`=1 is ignored; no queueing.
- Operand inputs are don't-care after accept.

## Timing
- Reset (async, `rst_n`=0) forces immediately: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset asserted mid-operation abandons the operation with no result write.
- Let edge k accept `start`. Then:
  - `busy`=1 after edges k..k+WIDTH (WIDTH+1 cycles).
  - RUN iterations occur at edges k+1..k+WIDTH.
  - At edge k+WIDTH+1, FIX writes HI/LO, `busy`→0 and `done`→1 for exactly one cycle.
- Latency from accepting edge to valid HI/LO is WIDTH+1 cycles (33 for WIDTH=32), identical for all ops.
- A new `start` may be issued in the `done` cycle; it is accepted at the next edge. Back-to-back throughput is one op per WIDTH+2 cycles.
- `hi`/`lo` are register outputs; MFHI/MFLO read them combinationally with no extra latency.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 -> lo=3, hi=1, div_zero=0. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> hi=0x00001234, lo=0xFFFFFFFF, div_zero=1. A following MULTU 2×3 -> lo=6, hi=0, div_zero=0.
- MTHI 0xAAAA0000 while idle -> hi=0xAAAA0000 next cycle. MTLO while busy -> lo unchanged. `start` with a different op while busy -> ignored; the original result is unaffected.
- Start MULTU 0xFFFF×0xFFFF, drop `rst_n` at cycle 10 -> busy=0, hi=lo=0 immediately, no `done`. After release, DIVU 100/7 -> lo=14, hi=2.
